// File: rtl/fft_frame_packer_pkg.sv
// Shared FFT framing constants, read-side state encoding and the bit-reversal helper
// used by both the FFT core and the frame packer.
package fft_frame_packer_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int FFT_DW    = 32;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_VALID = 2'd1,
    R_HOLD  = 2'd2
  } rstate_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] idx);
    logic [FFT_LOG2N-1:0] r;
    for (int b = 0; b < FFT_LOG2N; b++) r[b] = idx[FFT_LOG2N-1-b];
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One half of the ping-pong frame store: 16 bins, single write port,
// every bin visible in parallel, cleared by reset.
module fft_frame_bank
  import fft_frame_packer_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [FFT_LOG2N-1:0]       waddr_i,
  input  logic [DW-1:0]              wdata_i,
  output logic [FFT_N-1:0][DW-1:0]   rdata_o
);

  logic [FFT_N-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q;

endmodule

// File: rtl/fft_frame_packer.sv
// Reorders a serial bit-reversed FFT bin stream into natural-order 16-bin frames and
// hands them to the analyzer; the write bank fills while the read bank is being analysed.
module fft_frame_packer
  import fft_frame_packer_pkg::*;
#(
  parameter int DW     = FFT_DW,
  parameter bit BITREV = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          done,
  output logic          fft_valid,
  output logic [DW-1:0] fft_d0,
  output logic [DW-1:0] fft_d1,
  output logic [DW-1:0] fft_d2,
  output logic [DW-1:0] fft_d3,
  output logic [DW-1:0] fft_d4,
  output logic [DW-1:0] fft_d5,
  output logic [DW-1:0] fft_d6,
  output logic [DW-1:0] fft_d7,
  output logic [DW-1:0] fft_d8,
  output logic [DW-1:0] fft_d9,
  output logic [DW-1:0] fft_d10,
  output logic [DW-1:0] fft_d11,
  output logic [DW-1:0] fft_d12,
  output logic [DW-1:0] fft_d13,
  output logic [DW-1:0] fft_d14,
  output logic [DW-1:0] fft_d15,
  output logic [7:0]    frame_cnt,
  output logic          overrun
);

  rstate_e              state_q, state_d;
  logic [FFT_LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic                 wfull_q, wfull_d;
  logic                 wsel_q, rsel_q;
  logic [7:0]           frame_cnt_q;
  logic                 overrun_q, overrun_d;
  logic                 hs, swap;
  logic [FFT_LOG2N-1:0] waddr;

  logic [FFT_N-1:0][DW-1:0] rd0, rd1, frame;

  assign in_ready = !wfull_q;
  assign hs       = in_valid && !wfull_q;
  assign waddr    = BITREV ? bitrev4(wr_cnt_q) : wr_cnt_q;

  fft_frame_bank #(.DW(DW)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (hs && !wsel_q),
    .waddr_i (waddr),
    .wdata_i (in_data),
    .rdata_o (rd0)
  );

  fft_frame_bank #(.DW(DW)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we_i    (hs && wsel_q),
    .waddr_i (waddr),
    .wdata_i (in_data),
    .rdata_o (rd1)
  );

  // swap hands the freshly filled bank to the reader in the same edge the FSM enters R_VALID
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (wfull_q) begin
          swap    = 1'b1;
          state_d = R_VALID;
        end
      end
      R_VALID: state_d = R_HOLD;
      R_HOLD: begin
        if (done) begin
          if (wfull_q) begin
            swap    = 1'b1;
            state_d = R_VALID;
          end else begin
            state_d = R_IDLE;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_cnt_d  = hs ? wr_cnt_q + 1'b1 : wr_cnt_q;
    wfull_d   = wfull_q;
    if (swap) begin
      wfull_d = 1'b0;
    end else if (hs && (wr_cnt_q == FFT_LOG2N'(FFT_N - 1))) begin
      wfull_d = 1'b1;
    end
    overrun_d = overrun_q || (done && (state_q == R_IDLE || state_q == R_VALID));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= R_IDLE;
      wr_cnt_q    <= '0;
      wfull_q     <= 1'b0;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b1;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      wfull_q   <= wfull_d;
      overrun_q <= overrun_d;
      if (swap) begin
        wsel_q      <= ~wsel_q;
        rsel_q      <= ~rsel_q;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign frame     = rsel_q ? rd1 : rd0;
  assign fft_valid = (state_q == R_VALID);
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;

  assign fft_d0  = frame[0];
  assign fft_d1  = frame[1];
  assign fft_d2  = frame[2];
  assign fft_d3  = frame[3];
  assign fft_d4  = frame[4];
  assign fft_d5  = frame[5];
  assign fft_d6  = frame[6];
  assign fft_d7  = frame[7];
  assign fft_d8  = frame[8];
  assign fft_d9  = frame[9];
  assign fft_d10 = frame[10];
  assign fft_d11 = frame[11];
  assign fft_d12 = frame[12];
  assign fft_d13 = frame[13];
  assign fft_d14 = frame[14];
  assign fft_d15 = frame[15];

endmodule

// File: tb/tb_fft_frame_packer.sv
// Self-checking bench for fft_frame_packer: directed table, multi-cycle corner
// sequences, and a randomized run against a queue-based frame model.
`timescale 1ns/1ps
module tb_fft_frame_packer;

  localparam int DW = 32;
  typedef logic [15:0][DW-1:0] frame_t;
  typedef struct {
    logic [DW-1:0] din;
    int            idx;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, done;
  logic [DW-1:0] in_data;
  logic          in_ready, fft_valid, overrun;
  logic [7:0]    frame_cnt;
  logic [DW-1:0] fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
  logic [DW-1:0] fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15;
  frame_t        dout;

  fft_frame_packer #(.DW(DW), .BITREV(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .done(done), .fft_valid(fft_valid),
    .fft_d0(fft_d0), .fft_d1(fft_d1), .fft_d2(fft_d2), .fft_d3(fft_d3),
    .fft_d4(fft_d4), .fft_d5(fft_d5), .fft_d6(fft_d6), .fft_d7(fft_d7),
    .fft_d8(fft_d8), .fft_d9(fft_d9), .fft_d10(fft_d10), .fft_d11(fft_d11),
    .fft_d12(fft_d12), .fft_d13(fft_d13), .fft_d14(fft_d14), .fft_d15(fft_d15),
    .frame_cnt(frame_cnt), .overrun(overrun)
  );

  assign dout[0]  = fft_d0;   assign dout[1]  = fft_d1;
  assign dout[2]  = fft_d2;   assign dout[3]  = fft_d3;
  assign dout[4]  = fft_d4;   assign dout[5]  = fft_d5;
  assign dout[6]  = fft_d6;   assign dout[7]  = fft_d7;
  assign dout[8]  = fft_d8;   assign dout[9]  = fft_d9;
  assign dout[10] = fft_d10;  assign dout[11] = fft_d11;
  assign dout[12] = fft_d12;  assign dout[13] = fft_d13;
  assign dout[14] = fft_d14;  assign dout[15] = fft_d15;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int vcount = 0;
  bit abort = 1'b0;
  int br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  logic [DW-1:0] bins_q[$];

  always @(posedge clk) if (fft_valid === 1'b1) vcount++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_frame(input string nm, input frame_t exp);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_d%0d", nm, k), 64'(dout[k]), 64'(exp[k]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one bin; returns at the negedge before the edge that accepts it.
  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    while (in_ready !== 1'b1) begin
      n++;
      if (n > 200 || abort) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=in_ready_low required=accept_within_200");
        in_valid = 1'b0;
        abort = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (fft_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    check({nm, "_fft_valid"}, 64'(fft_valid), 64'd0);
    check({nm, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    check({nm, "_overrun"}, 64'(overrun), 64'd0);
    check_frame({nm, "_frame"}, '0);
  endtask

  initial begin
    vec_t   tbl[16];
    frame_t fa, fb, exp;
    logic [DW-1:0] src[32];
    int     v0;
    bit     ok;

    rst = 1'b1; in_valid = 1'b0; done = 1'b0; in_data = '0;
    for (int k = 0; k < 16; k++) begin
      tbl[k].din = 32'h0001_0000 * k;
      tbl[k].idx = br[k];
    end
    repeat (2) @(negedge clk);
    check_reset_vals("t1_por");
    rst = 1'b0;

    // T5: done while idle sets overrun only
    v0 = vcount;
    pulse_done();
    repeat (3) @(negedge clk);
    check("t5_overrun", 64'(overrun), 64'd1);
    check("t5_no_valid", 64'(vcount - v0), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    do_reset();
    check("t5_overrun_cleared", 64'(overrun), 64'd0);

    // T2: bit-reversed directed frame and latency
    for (int k = 0; k < 16; k++) send(tbl[k].din);
    idle();
    check("t2_valid_T1", 64'(fft_valid), 64'd0);
    check("t2_ready_T1", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("t2_valid_T2", 64'(fft_valid), 64'd1);
    check("t2_frame_cnt", 64'(frame_cnt), 64'd1);
    for (int k = 0; k < 16; k++)
      check($sformatf("t2_d%0d", tbl[k].idx), 64'(dout[tbl[k].idx]), 64'(tbl[k].din));
    @(negedge clk);
    check("t2_pulse_1cyc", 64'(fft_valid), 64'd0);

    // T1: reset asserted mid-stream while a frame is held
    for (int k = 0; k < 5; k++) send($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals("t1_mid");
    @(negedge clk);
    rst = 1'b0;
    v0 = vcount;
    repeat (5) @(negedge clk);
    check("t1_no_pulse", 64'(vcount - v0), 64'd0);
    for (int k = 0; k < 16; k++) begin
      src[k] = $urandom;
      exp[br[k]] = src[k];
    end
    for (int k = 0; k < 16; k++) send(src[k]);
    idle();
    wait_valid(10, ok);
    check("t1_post_valid", 64'(ok), 64'd1);
    check_frame("t1_post", exp);
    check("t1_post_cnt", 64'(frame_cnt), 64'd1);
    pulse_done();

    // T3/T4: two frames with done held off, then back-to-back release
    do_reset();
    v0 = vcount;
    for (int k = 0; k < 32; k++) src[k] = $urandom;
    for (int k = 0; k < 16; k++) begin
      fa[br[k]] = src[k];
      fb[br[k]] = src[k + 16];
    end
    for (int k = 0; k < 32; k++) send(src[k]);
    idle();
    repeat (3) @(negedge clk);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_one_valid", 64'(vcount - v0), 64'd1);
    check("t3_frame_cnt", 64'(frame_cnt), 64'd1);
    check_frame("t3_hold", fa);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("t4_valid_next", 64'(fft_valid), 64'd1);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd2);
    check("t4_in_ready", 64'(in_ready), 64'd1);
    check_frame("t4_frame2", fb);
    pulse_done();
    @(negedge clk);
    check("t4_overrun", 64'(overrun), 64'd0);

    // T6: randomized gaps and analyzer delays over 300 frames
    do_reset();
    bins_q.delete();
    v0 = vcount;
    fork
      begin : driver
        logic [DW-1:0] d;
        for (int f = 0; f < 300 && !abort; f++) begin
          for (int k = 0; k < 16 && !abort; k++) begin
            while ($urandom_range(0, 1) == 1) begin
              @(negedge clk);
              in_valid = 1'b0;
            end
            d = $urandom;
            bins_q.push_back(d);
            send(d);
          end
        end
        idle();
      end
      begin : analyzer
        frame_t ef;
        bit     got;
        int     hold;
        for (int f = 1; f <= 300 && !abort; f++) begin
          wait_valid(2000, got);
          if (!got) begin
            checks++;
            failures++;
            $display("FAIL t6_valid_timeout frame=%0d actual=no_pulse required=pulse", f);
            abort = 1'b1;
            break;
          end
          for (int k = 0; k < 16; k++) ef[br[k]] = bins_q.pop_front();
          check_frame($sformatf("t6_f%0d", f), ef);
          check($sformatf("t6_cnt_f%0d", f), 64'(frame_cnt), 64'(f % 256));
          hold = $urandom_range(1, 6);
          repeat (hold) begin
            @(negedge clk);
            check($sformatf("t6_nodup_f%0d", f), 64'(fft_valid), 64'd0);
          end
          check_frame($sformatf("t6_stable_f%0d", f), ef);
          done = 1'b1;
          @(negedge clk);
          done = 1'b0;
        end
      end
    join
    repeat (3) @(negedge clk);
    check("t6_total_frames", 64'(vcount - v0), 64'd300);
    check("t6_no_leftover", 64'(bins_q.size()), 64'd0);
    check("t6_final_cnt", 64'(frame_cnt), 64'(300 % 256));
    check("t6_overrun", 64'(overrun), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
